// File: rtl/fft_bitrev_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_pkg
// Shared definitions for the receive chain between cyclic-prefix removal and
// the radix-2 FFT core.
//   N_LOG2_DEF / DATA_W_DEF : default FFT size (log2) and sample width.
//   sample_t                : packed complex sample, {I[15:0], Q[15:0]}.
//   bitrev()                : mirrors the low 'nbits' bits of an index.
// ---------------------------------------------------------------------------
package fft_bitrev_pkg;

   localparam int N_LOG2_DEF   = 6;
   localparam int DATA_W_DEF   = 32;
   localparam int BITREV_MAX_W = 16;

   typedef struct packed {
      logic signed [15:0] i;
      logic signed [15:0] q;
   } sample_t;

   // Shift the index out LSB-first and into the result LSB-first, so bit 0
   // of the index lands on bit nbits-1 of the result.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(
      input logic [BITREV_MAX_W-1:0] idx,
      input int                      nbits
   );
      logic [BITREV_MAX_W-1:0] r;
      logic [BITREV_MAX_W-1:0] v;
      r = '0;
      v = idx;
      for (int b = 0; b < nbits; b++) begin
         r = {r[BITREV_MAX_W-2:0], v[0]};
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pingpong_ram.sv
// ---------------------------------------------------------------------------
// pingpong_ram
// Two banks of N x DATA_W held in one array; the bank select is the address
// MSB. One write port, one synchronous read port (registered output that
// holds its value while re is low).
//   clock        : rising-edge clock
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address
//   rdata        : read data, valid the cycle after re
// ---------------------------------------------------------------------------
module pingpong_ram
   import fft_bitrev_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              we,
   input  logic [N_LOG2:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [N_LOG2:0]   raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(2 << N_LOG2)-1];

   // NOTE: storage arrays get no reset; the full flags decide what is valid,
   // and a reset port here would stop the array mapping onto block RAM.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_bitrev_buffer.sv
// ---------------------------------------------------------------------------
// fft_bitrev_buffer
// Ping-pong reorder buffer: takes symbols of N = 2^N_LOG2 samples in natural
// order and emits each one in bit-reversed order, one sample per cycle.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : natural-order input stream
//   m_valid/m_ready/m_data/m_last : bit-reversed output stream
//   err_frame            : one-cycle pulse when s_last disagrees with the count
//   sym_count            : number of symbols fully delivered (wraps)
// Read path: issue (RAM read) -> p1 (RAM output register) -> output register.
// The issue pointer runs ahead of delivery, so the next bank's first sample
// is read while the previous symbol's final sample is still being offered.
// ---------------------------------------------------------------------------
module fft_bitrev_buffer
   import fft_bitrev_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              err_frame,
   output logic [CNT_W-1:0]  sym_count
);

   typedef logic [N_LOG2-1:0] idx_t;

   logic [1:0]        full, full_nxt;
   logic              wr_sel, rd_sel, iss_sel;
   idx_t              wr_idx, iss_idx, iss_addr;
   logic              p1_valid, p1_last;
   logic              s_fire, wr_end, m_fire, release_bank, pipe_en, issue;
   logic [DATA_W-1:0] ram_rdata;

   // NOTE: every signal gets its value before any conditional update, so no
   // path through this block can leave one unassigned and infer a latch.
   always_comb begin
      s_ready      = !reset && !full[wr_sel];
      s_fire       = s_valid && s_ready;
      wr_end       = s_fire && (&wr_idx);
      m_fire       = m_valid && m_ready;
      release_bank = m_fire && m_last;
      // The whole read pipeline advances together; it only stalls when the
      // output register holds a sample the FFT has not taken.
      pipe_en      = !m_valid || m_ready;
      issue        = !reset && pipe_en && full[iss_sel];
      iss_addr     = idx_t'(bitrev(BITREV_MAX_W'(iss_idx), N_LOG2));
      full_nxt     = full;
      if (release_bank) full_nxt[rd_sel] = 1'b0;
      // Applied second so a completing write wins over a release of the
      // same bank on the same edge.
      if (wr_end)       full_nxt[wr_sel] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         full      <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         iss_sel   <= 1'b0;
         wr_idx    <= '0;
         iss_idx   <= '0;
         p1_valid  <= 1'b0;
         p1_last   <= 1'b0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         err_frame <= 1'b0;
         sym_count <= '0;
      end else begin
         full <= full_nxt;

         // A framing error is s_last arriving anywhere but the final slot,
         // or the final slot arriving without s_last.
         err_frame <= s_fire && (s_last != (&wr_idx));

         // An early s_last drops the partial symbol without flipping banks.
         if (s_fire && s_last) wr_idx <= '0;
         else if (s_fire)      wr_idx <= wr_idx + idx_t'(1);
         if (wr_end)           wr_sel <= !wr_sel;

         if (issue) begin
            iss_idx <= iss_idx + idx_t'(1);
            if (&iss_idx) iss_sel <= !iss_sel;
         end

         if (pipe_en) begin
            p1_valid <= issue;
            p1_last  <= issue && (&iss_idx);
            m_valid  <= p1_valid;
            m_last   <= p1_last;
         end

         if (release_bank) begin
            rd_sel    <= !rd_sel;
            sym_count <= sym_count + CNT_W'(1);
         end
      end
   end

   // Data path register; qualified by m_valid, so it needs no reset.
   always_ff @(posedge clock) begin
      if (pipe_en) m_data <= ram_rdata;
   end

   pingpong_ram #(
      .N_LOG2 (N_LOG2),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .we    (s_fire),
      .waddr ({wr_sel, wr_idx}),
      .wdata (s_data),
      .re    (issue),
      .raddr ({iss_sel, iss_addr}),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_buffer
// Scoreboard bench for fft_bitrev_buffer with N = 8. A reference model
// collects accepted input samples into symbols and pushes the bit-reversed
// expectation into a queue; a separate monitor pops and compares outputs.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_buffer;

   localparam int N_LOG2 = 3;
   localparam int N      = 1 << N_LOG2;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              err_frame;
   logic [CNT_W-1:0]  sym_count;

   fft_bitrev_buffer #(
      .N_LOG2 (N_LOG2),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .err_frame (err_frame),
      .sym_count (sym_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] sym_buf[$];
   int                pop_cyc[$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, n_acc = 0, n_pop = 0, err_cnt = 0;
   int first_valid_edge = -1, last_in_edge = -1;
   bit rand_ready = 1'b0;
   bit bp_done = 1'b0;
   logic [DATA_W-1:0] vals[24];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int rev_index(input int j);
      int r = 0;
      int v = j;
      for (int b = 0; b < N_LOG2; b++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return rev_index_ret(r);
   endfunction

   function automatic int rev_index_ret(input int r);
      return r;
   endfunction

   // Reference model: a symbol is complete after N samples whatever s_last
   // says; an s_last before that throws the partial symbol away.
   function automatic void model_accept(input logic [DATA_W-1:0] d, input logic last);
      exp_t e;
      sym_buf.push_back(d);
      if (sym_buf.size() == N) begin
         for (int j = 0; j < N; j++) begin
            e.data = sym_buf[rev_index(j)];
            e.last = (j == N - 1);
            exp_q.push_back(e);
         end
         sym_buf.delete();
      end else if (last) begin
         sym_buf.delete();
      end
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Random backpressure for the soak phase.
   initial forever begin
      @(posedge clock);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: compares every accepted output and checks stability under stall.
   initial begin
      exp_t e;
      bit hold_pending;
      logic [DATA_W-1:0] held_data;
      logic held_last;
      hold_pending = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold_pending = 1'b0;
         end else begin
            if (err_frame) err_cnt++;
            if (m_valid && first_valid_edge < 0) first_valid_edge = cyc;
            if (hold_pending) begin
               check("hold_valid", 64'(m_valid), 1);
               check("hold_data", 64'(m_data), 64'(held_data));
               check("hold_last", 64'(m_last), 64'(held_last));
               hold_pending = 1'b0;
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 64'(m_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", 64'(m_data), 64'(e.data));
                  check("m_last", 64'(m_last), 64'(e.last));
                  n_pop++;
                  pop_cyc.push_back(cyc);
               end
            end else if (m_valid) begin
               hold_pending = 1'b1;
               held_data = m_data;
               held_last = m_last;
            end
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      int waited = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      @(negedge clock);
      while (!s_ready && waited < 400) begin
         @(negedge clock);
         waited++;
      end
      if (!s_ready) begin
         check("send_ready_timeout", 64'(s_ready), 1);
         s_valid = 1'b0;
         return;
      end
      n_acc++;
      last_in_edge = cyc + 1;
      model_accept(d, last);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 1000) begin
         @(negedge clock);
         w++;
      end
      check("drain_empty", 64'(exp_q.size()), 0);
      repeat (3) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      s_valid = 1'b0;
      s_last = 1'b0;
      rand_ready = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_s_ready_low", 64'(s_ready), 0);
      check("reset_m_valid", 64'(m_valid), 0);
      exp_q.delete();
      sym_buf.delete();
      pop_cyc.delete();
      n_acc = 0;
      n_pop = 0;
      err_cnt = 0;
      first_valid_edge = -1;
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_s_ready", 64'(s_ready), 1);
      check("post_reset_m_valid", 64'(m_valid), 0);
      check("post_reset_m_last", 64'(m_last), 0);
      check("post_reset_err_frame", 64'(err_frame), 0);
      check("post_reset_sym_count", 64'(sym_count), 0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      int w;

      // Single symbol: order, latency, count.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) send(DATA_W'(i), i == N - 1);
      idle(1);
      drain();
      check("single_latency", 64'(first_valid_edge - last_in_edge), 2);
      check("single_sym_count", 64'(sym_count), 1);
      check("single_n_pop", 64'(n_pop), 8);
      check("single_err_cnt", 64'(err_cnt), 0);

      // Back-to-back streaming of four symbols.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 4 * N; i++) send(DATA_W'(i), (i % N) == N - 1);
      idle(1);
      drain();
      check("stream_sym_count", 64'(sym_count), 4);
      check("stream_n_pop", 64'(pop_cyc.size()), 32);
      if (pop_cyc.size() == 32) begin
         for (int s = 0; s < 4; s++) begin
            gaps = 0;
            for (int k = 1; k < N; k++)
               if (pop_cyc[s * N + k] != pop_cyc[s * N + k - 1] + 1) gaps++;
            check($sformatf("stream_sym%0d_gaps", s), 64'(gaps), 0);
         end
         check("stream_sym0_to_sym1_gap", 64'(pop_cyc[N] - pop_cyc[N - 1]), 1);
      end

      // Backpressure: both banks fill, the 17th sample stalls.
      do_reset();
      m_ready = 1'b0;
      bp_done = 1'b0;
      for (int i = 0; i < 24; i++) vals[i] = $urandom;
      fork
         begin
            for (int i = 0; i < 24; i++) send(vals[i], (i % N) == N - 1);
            idle(1);
            bp_done = 1'b1;
         end
      join_none
      repeat (40) @(posedge clock);
      @(negedge clock);
      check("bp_accepted", 64'(n_acc), 16);
      check("bp_s_ready", 64'(s_ready), 0);
      check("bp_m_valid", 64'(m_valid), 1);
      check("bp_m_data_head", 64'(m_data), 64'(vals[0]));
      @(posedge clock);
      #1;
      m_ready = 1'b1;
      w = 0;
      while (!bp_done && w < 1000) begin
         @(posedge clock);
         w++;
      end
      check("bp_driver_done", 64'(bp_done), 1);
      drain();
      check("bp_sym_count", 64'(sym_count), 3);
      check("bp_n_pop", 64'(n_pop), 24);

      // Early s_last then a good symbol.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) send($urandom, i == 4);
      for (int i = 0; i < N; i++) send(DATA_W'(100 + i), i == N - 1);
      idle(1);
      drain();
      check("early_err_cnt", 64'(err_cnt), 1);
      check("early_sym_count", 64'(sym_count), 1);
      check("early_n_pop", 64'(n_pop), 8);

      // Missing s_last: kept, reordered, flagged.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) send($urandom, 1'b0);
      idle(1);
      drain();
      check("missing_err_cnt", 64'(err_cnt), 1);
      check("missing_sym_count", 64'(sym_count), 1);
      check("missing_n_pop", 64'(n_pop), 8);

      // Mid-operation reset after three output samples.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) send(DATA_W'(200 + i), i == N - 1);
      idle(0);
      w = 0;
      while (n_pop < 3 && w < 200) begin
         @(posedge clock);
         w++;
      end
      check("midrst_reached_3", 64'(n_pop), 3);
      #1;
      reset = 1'b1;
      exp_q.delete();
      sym_buf.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("midrst_m_valid", 64'(m_valid), 0);
      check("midrst_sym_count", 64'(sym_count), 0);
      @(posedge clock);
      #1;
      idle(20);
      check("midrst_no_residue", 64'(n_pop), 3);
      for (int i = 0; i < N; i++) send($urandom, i == N - 1);
      idle(1);
      drain();
      check("midrst_fresh_sym_count", 64'(sym_count), 1);
      check("midrst_fresh_n_pop", 64'(n_pop), 11);

      // Randomized soak: random data, input gaps and output backpressure.
      do_reset();
      rand_ready = 1'b1;
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < N; i++) begin
            idle($urandom_range(0, 2));
            send($urandom, i == N - 1);
         end
      end
      idle(1);
      drain();
      rand_ready = 1'b0;
      m_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("rand_sym_count", 64'(sym_count), 6);
      check("rand_n_pop", 64'(n_pop), 48);
      check("rand_err_cnt", 64'(err_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Ping-pong reorder buffer between cyclic prefix removal and the radix-2 FFT core.
- Accepts CP-stripped OFDM symbols of 2^N_LOG2 complex samples in natural order.
- Emits each symbol in bit-reversed index order, one sample per cycle.
- Checks symbol framing against s_last and counts delivered symbols.

Parameters:
- N_LOG2, 6, log2 of FFT size (symbol length N = 2^N_LOG2 samples).
- DATA_W, 32, sample width ({I[15:0], Q[15:0]}, passed through untouched).
- CNT_W, 16, width of the delivered-symbol counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  buffer can accept a sample.
- s_data  in  DATA_W  input sample, natural order.
- s_last  in  1  marks final sample of the input symbol.
- m_valid  out  1  output sample valid.
- m_ready  in  1  FFT accepts the sample.
- m_data  out  DATA_W  output sample, bit-reversed order.
- m_last  out  1  high on output sample N-1 of a symbol.
- err_frame  out  1  one-cycle pulse on a framing error.
- sym_count  out  CNT_W  symbols fully delivered; wraps.

Behaviour:
- Reset values: s_ready=0 in the reset cycle then 1; m_valid=0, m_last=0, err_frame=0, sym_count=0. Both banks empty, wr_sel=0, rd_sel=0.
- Reset asserted mid-operation discards partial and full banks. No output may complete after reset.
- Transfers occur on valid&&ready at the rising edge. m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Write side:
  - s_ready = !full[wr_sel].
  - Accepted sample k (0..N-1) is written to bank[wr_sel][k].
  - On k=N-1: full[wr_sel] is set, wr_sel toggles, k clears.
- Framing:
  - s_last on k<N-1: partial symbol is dropped, k clears, no bank flip, err_frame pulses next cycle.
  - k=N-1 with s_last=0: symbol is kept and flipped, err_frame pulses.
  - s_last on k=N-1: normal completion, no pulse.
- Read side:
  - While full[rd_sel], output j (0..N-1) carries bank[rd_sel][bitrev(j)], where bitrev mirrors the N_LOG2 address bits.
  - m_last = (j==N-1).
  - On acceptance of j=N-1: full[rd_sel] clears, rd_sel toggles, sym_count increments modulo 2^CNT_W.
- Latency: if the final input sample is accepted in cycle T with the read side idle, m_valid is first high in cycle T+2. Synchronous RAM read is one cycle, plus the output register.
- Throughput: with m_ready held high and input streaming, one sample per cycle sustained. No bubble between consecutive output symbols; the next bank's first read is prefetched during the previous symbol's final sample.
- Both banks full: s_ready=0 until the read side releases a bank. The bank is writable in the cycle after its final sample is accepted.
- Simultaneous events:
  - A write completing into one bank while the other bank's last sample is read updates both flags in the same edge.
  - When the write completes into the bank being released on that same edge, the write takes priority. This case cannot occur while s_ready gates writes.
- sym_count wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Package fft_bitrev_pkg holds:
  - the bitrev function (parameterised by N_LOG2);
  - the sample typedef (packed I/Q, 16+16);
  - the default N_LOG2/DATA_W constants shared with the CP-removal wrapper and the FFT.
- Sub-module pingpong_ram: two banks of N x DATA_W, one write port and one synchronous read port, bank select folded into the address MSB.
- fft_bitrev_buffer holds the counters, full flags, prefetch and the output register.

Test Plan (N_LOG2=3, N=8):
- Single symbol:
  - Stimulus: samples 0..7 with s_last on 7, m_ready=1.
  - Response: output 0,4,2,6,1,5,3,7; m_last only on 7; first m_valid 2 cycles after the last input; sym_count=1.
- Back-to-back streaming:
  - Stimulus: 4 continuous symbols (values 0..31), m_ready=1.
  - Response: 32 consecutive m_valid cycles with no gaps after the first; each symbol bit-reversed within itself; sym_count=4.
- Backpressure:
  - Stimulus: m_ready=0 while 3 symbols are offered.
  - Response: s_ready drops after 16 accepted samples and the 17th stalls; m_data stays at sample 0 of symbol 0. Releasing m_ready drains the symbols in order with no loss.
- Early s_last:
  - Stimulus: 5 samples with s_last on the 5th, then a good symbol 100..107.
  - Response: err_frame pulses once; the output is only the reordered 100..107; sym_count=1.
- Missing s_last:
  - Stimulus: 8 samples with s_last=0.
  - Response: err_frame pulses and the symbol is still output bit-reversed.
- Mid-operation reset:
  - Stimulus: reset asserted for 1 cycle after 3 output samples.
  - Response: m_valid=0 and sym_count=0 the next cycle; no residual data is emitted; a fresh symbol then reorders correctly.
